// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, error and status records plus the chain FSM state encoding.
package dma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  err_type;
        logic [31:0] addr;
    } s_dma_error_t;

    typedef struct packed {
        logic active;
        logic done;
        logic error;
    } s_dma_status_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dma_chain_st_t;

    // The AXI error outranks the read streamer, which outranks the write streamer.
    function automatic s_dma_error_t pick_first_err(input s_dma_error_t axi_err,
                                                    input s_dma_error_t rd_err,
                                                    input s_dma_error_t wr_err);
        if (axi_err.valid)     return axi_err;
        else if (rd_err.valid) return rd_err;
        else                   return wr_err;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor queue with push/pop/flush and a combinationally visible head entry.
module dma_desc_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           din,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // A flush drops the queued entries but keeps a descriptor accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (flush) begin
                rd_ptr <= wr_ptr;
                cnt    <= push_ok ? CW'(1) : '0;
            end else begin
                if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

endmodule

// File: rtl/dma_chain_fsm.sv
// Chained-descriptor DMA control FSM. Define DMA_CHAIN_ABORT_EN to add the dma_abort_i port.
module dma_chain_fsm
    import dma_pkg::*;
#(
    parameter int DESC_DEPTH  = 4,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            desc_valid_i,
    output logic                            desc_ready_o,
    input  s_dma_desc_t                     desc_i,
    input  logic                            dma_go_i,
    output s_dma_status_t                   dma_stats_o,
    output s_dma_error_t                    dma_error_o,
    output logic [$clog2(DESC_DEPTH+1)-1:0] desc_cnt_o,
    output logic [CNT_W-1:0]                desc_done_cnt_o,
    input  logic                            axi_pend_txn_i,
    input  s_dma_error_t                    axi_txn_err_i,
    output logic                            clear_dma_o,
    output logic                            dma_active_o,
    output s_dma_desc_t                     cur_desc_o,
    output logic                            dma_stream_rd_valid_o,
    input  logic                            dma_stream_rd_done_i,
    input  s_dma_error_t                    dma_stream_rd_err_i,
    output logic                            dma_stream_wr_valid_o,
    input  logic                            dma_stream_wr_done_i,
`ifdef DMA_CHAIN_ABORT_EN
    input  logic                            dma_abort_i,
`endif
    input  s_dma_error_t                    dma_stream_wr_err_i
);

    localparam int QW = $clog2(DESC_DEPTH+1);

    dma_chain_st_t   state, next_state;
    s_dma_desc_t     head;
    s_dma_error_t    err_q;
    logic [QW-1:0]   q_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic            q_full, q_empty;
    logic            push, pop, flush;
    logic            rd_done_ff, wr_done_ff;
    logic            rd_cmp, wr_cmp, has_bytes;
    logic            err_lock, err_hpn, go_clr, cnt_inc;

    assign desc_ready_o = !q_full;
    assign push         = desc_valid_i && !q_full;

    dma_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .T     (s_dma_desc_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (desc_i),
        .head  (head),
        .count (q_cnt),
        .full  (q_full),
        .empty (q_empty)
    );

    assign has_bytes = (head.num_bytes != '0);
    assign rd_cmp    = rd_done_ff || dma_stream_rd_done_i || !has_bytes;
    assign wr_cmp    = wr_done_ff || dma_stream_wr_done_i || !has_bytes;
    assign err_hpn   = (axi_txn_err_i.valid || dma_stream_rd_err_i.valid || dma_stream_wr_err_i.valid)
                       && ((state == RUN) || (state == DRAIN));

    always_comb begin
        next_state            = state;
        pop                   = 1'b0;
        flush                 = 1'b0;
        go_clr                = 1'b0;
        cnt_inc               = 1'b0;
        clear_dma_o           = 1'b0;
        dma_stream_rd_valid_o = 1'b0;
        dma_stream_wr_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (dma_go_i) begin
                    go_clr     = 1'b1;
                    next_state = q_empty ? DRAIN : RUN;
                end
            end
            RUN: begin
                dma_stream_rd_valid_o = has_bytes && !rd_done_ff;
                dma_stream_wr_valid_o = has_bytes && !wr_done_ff;
`ifdef DMA_CHAIN_ABORT_EN
                if (dma_abort_i) begin
                    flush      = 1'b1;
                    next_state = DRAIN;
                end else
`endif
                if (STOP_ON_ERR && err_hpn) begin
                    flush      = 1'b1;
                    next_state = DRAIN;
                end else if (rd_cmp && wr_cmp) begin
                    pop        = 1'b1;
                    cnt_inc    = 1'b1;
                    next_state = ((q_cnt > QW'(1)) || push) ? RUN : DRAIN;
                end
            end
            DRAIN: begin
                if (!axi_pend_txn_i) next_state = DONE;
            end
            DONE: begin
                if (!dma_go_i) begin
                    clear_dma_o = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            rd_done_ff <= 1'b0;
            wr_done_ff <= 1'b0;
            err_lock   <= 1'b0;
            err_q      <= '0;
            done_cnt   <= '0;
        end else begin
            state <= next_state;
            if ((state != RUN) || pop || flush) begin
                rd_done_ff <= 1'b0;
                wr_done_ff <= 1'b0;
            end else begin
                if (dma_stream_rd_done_i) rd_done_ff <= 1'b1;
                if (dma_stream_wr_done_i) wr_done_ff <= 1'b1;
            end
            // Only the first error after a go is kept; the lock holds it until the next go.
            if (go_clr) begin
                err_q    <= '0;
                err_lock <= 1'b0;
                done_cnt <= '0;
            end else begin
                if (err_hpn && !err_lock) begin
                    err_q    <= pick_first_err(axi_txn_err_i, dma_stream_rd_err_i, dma_stream_wr_err_i);
                    err_lock <= 1'b1;
                end
                if (cnt_inc) done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

    assign dma_active_o       = (state == RUN) || (state == DRAIN);
    assign dma_stats_o.active = dma_active_o;
    assign dma_stats_o.done   = (state == DONE);
    assign dma_stats_o.error  = err_q.valid;
    assign dma_error_o        = err_q;
    assign desc_cnt_o         = q_cnt;
    assign desc_done_cnt_o    = done_cnt;
    assign cur_desc_o         = q_empty ? '0 : head;

endmodule

// File: tb/tb_dma_chain_fsm.sv
// Directed bench for dma_chain_fsm; abort scenario runs when DMA_CHAIN_ABORT_EN is defined.
module tb_dma_chain_fsm;
    import dma_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          desc_valid;
    logic          desc_ready;
    s_dma_desc_t   desc;
    logic          go;
    s_dma_status_t stats;
    s_dma_error_t  err;
    logic [2:0]    desc_cnt;
    logic [15:0]   done_cnt;
    logic          axi_pend;
    s_dma_error_t  axi_err;
    logic          clear_dma;
    logic          active;
    s_dma_desc_t   cur_desc;
    logic          rd_valid, rd_done;
    s_dma_error_t  rd_err;
    logic          wr_valid, wr_done;
    s_dma_error_t  wr_err;
`ifdef DMA_CHAIN_ABORT_EN
    logic          abort;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dma_chain_fsm dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .desc_valid_i          (desc_valid),
        .desc_ready_o          (desc_ready),
        .desc_i                (desc),
        .dma_go_i              (go),
        .dma_stats_o           (stats),
        .dma_error_o           (err),
        .desc_cnt_o            (desc_cnt),
        .desc_done_cnt_o       (done_cnt),
        .axi_pend_txn_i        (axi_pend),
        .axi_txn_err_i         (axi_err),
        .clear_dma_o           (clear_dma),
        .dma_active_o          (active),
        .cur_desc_o            (cur_desc),
        .dma_stream_rd_valid_o (rd_valid),
        .dma_stream_rd_done_i  (rd_done),
        .dma_stream_rd_err_i   (rd_err),
        .dma_stream_wr_valid_o (wr_valid),
        .dma_stream_wr_done_i  (wr_done),
`ifdef DMA_CHAIN_ABORT_EN
        .dma_abort_i           (abort),
`endif
        .dma_stream_wr_err_i   (wr_err)
    );

    function automatic s_dma_desc_t mk_desc(input logic [31:0] src, input logic [31:0] nbytes);
        s_dma_desc_t d;
        d.src_addr  = src;
        d.dst_addr  = src + 32'h1000;
        d.num_bytes = nbytes;
        return d;
    endfunction

    function automatic s_dma_error_t mk_err(input logic [1:0] t, input logic [31:0] addr);
        s_dma_error_t e;
        e.valid    = 1'b1;
        e.err_type = t;
        e.addr     = addr;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input s_dma_desc_t d);
        desc_valid = 1'b1;
        desc       = d;
        step();
        desc_valid = 1'b0;
    endtask

    // Completes n descriptors back to back, then walks DRAIN -> DONE -> IDLE (go and pend low).
    task automatic finish_chain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_done = 1'b1;
            wr_done = 1'b1;
            step();
        end
        rd_done = 1'b0;
        wr_done = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        #1;
        checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", desc_ready); end
        checks++; if (stats !== 3'b000) begin errors++; $display("FAIL reset_stats: got %0b expected 000", stats); end
        checks++; if (err !== '0) begin errors++; $display("FAIL reset_err: got %0h expected 0", err); end
        checks++; if (desc_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", desc_cnt); end
        checks++; if ({clear_dma, active, rd_valid, wr_valid} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {clear_dma, active, rd_valid, wr_valid}); end
        checks++; if (cur_desc !== '0) begin errors++; $display("FAIL reset_cur_desc: got %0h expected 0", cur_desc); end
    endtask

    task automatic test_chain();
        push_desc(mk_desc(32'h10, 32'd64));
        push_desc(mk_desc(32'h20, 32'd64));
        push_desc(mk_desc(32'h30, 32'd64));
        checks++; if (desc_cnt !== 3'd3) begin errors++; $display("FAIL chain_cnt: got %0d expected 3", desc_cnt); end
        go = 1'b1;
        step();
        checks++; if ({rd_valid, wr_valid} !== 2'b11) begin errors++; $display("FAIL chain_valids: got %b expected 11", {rd_valid, wr_valid}); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cur_desc.src_addr !== 32'h10 * (i + 1)) begin errors++; $display("FAIL chain_head%0d: got %0h expected %0h", i, cur_desc.src_addr, 32'h10 * (i + 1)); end
            rd_done = 1'b1;
            wr_done = 1'b1;
            #1;
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL chain_valid_at_done%0d: got %0b expected 1", i, rd_valid); end
            step();
            rd_done = 1'b0;
            wr_done = 1'b0;
            checks++; if (done_cnt !== 16'(i + 1)) begin errors++; $display("FAIL chain_done_cnt%0d: got %0d expected %0d", i, done_cnt, i + 1); end
            checks++; if (rd_valid !== (i < 2)) begin errors++; $display("FAIL chain_next_valid%0d: got %0b expected %0b", i, rd_valid, i < 2); end
        end
        checks++; if (active !== 1'b1 || desc_cnt !== 3'd0) begin errors++; $display("FAIL chain_drain: got active=%0b cnt=%0d expected 1 0", active, desc_cnt); end
        step();
        checks++; if (stats.done !== 1'b1) begin errors++; $display("FAIL chain_done: got %0b expected 1", stats.done); end
        step();
        checks++; if (stats.done !== 1'b1 || clear_dma !== 1'b0) begin errors++; $display("FAIL chain_hold_done: got done=%0b clear=%0b expected 1 0", stats.done, clear_dma); end
        go = 1'b0;
        #1;
        checks++; if (clear_dma !== 1'b1) begin errors++; $display("FAIL chain_clear: got %0b expected 1", clear_dma); end
        step();
        checks++; if (clear_dma !== 1'b0 || stats !== 3'b000) begin errors++; $display("FAIL chain_idle: got clear=%0b stats=%b expected 0 000", clear_dma, stats); end
    endtask

    task automatic test_zero_len();
        push_desc(mk_desc(32'hA0, 32'd0));
        push_desc(mk_desc(32'hB0, 32'd16));
        go = 1'b1;
        step();
        go = 1'b0;
        checks++; if ({rd_valid, wr_valid} !== 2'b00) begin errors++; $display("FAIL zero_valids: got %b expected 00", {rd_valid, wr_valid}); end
        step();
        checks++; if (cur_desc.src_addr !== 32'hB0 || rd_valid !== 1'b1 || done_cnt !== 16'd1) begin errors++; $display("FAIL zero_second: got src=%0h rv=%0b cnt=%0d expected b0 1 1", cur_desc.src_addr, rd_valid, done_cnt); end
        rd_done = 1'b1;
        wr_done = 1'b1;
        step();
        rd_done = 1'b0;
        wr_done = 1'b0;
        checks++; if (done_cnt !== 16'd2) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 2", done_cnt); end
        step();
        checks++; if (stats.done !== 1'b1 || clear_dma !== 1'b1) begin errors++; $display("FAIL zero_done_clear: got done=%0b clear=%0b expected 1 1", stats.done, clear_dma); end
        step();
    endtask

    task automatic test_full_no_bypass();
        for (int i = 0; i < 4; i++) push_desc(mk_desc(32'h100 + 32'(i), 32'd64));
        checks++; if (desc_ready !== 1'b0 || desc_cnt !== 3'd4) begin errors++; $display("FAIL full_state: got ready=%0b cnt=%0d expected 0 4", desc_ready, desc_cnt); end
        go = 1'b1;
        step();
        go = 1'b0;
        rd_done    = 1'b1;
        wr_done    = 1'b1;
        desc_valid = 1'b1;
        desc       = mk_desc(32'h200, 32'd64);
        #1;
        checks++; if (desc_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %0b expected 0", desc_ready); end
        step();
        rd_done = 1'b0;
        wr_done = 1'b0;
        checks++; if (desc_ready !== 1'b1 || desc_cnt !== 3'd3) begin errors++; $display("FAIL full_after_pop: got ready=%0b cnt=%0d expected 1 3", desc_ready, desc_cnt); end
        step();
        desc_valid = 1'b0;
        checks++; if (desc_cnt !== 3'd4) begin errors++; $display("FAIL full_push_next: got %0d expected 4", desc_cnt); end
        finish_chain(4);
        checks++; if (done_cnt !== 16'd5 || active !== 1'b0) begin errors++; $display("FAIL full_chain_end: got cnt=%0d active=%0b expected 5 0", done_cnt, active); end
    endtask

    task automatic test_stop_on_err();
        push_desc(mk_desc(32'h10, 32'd64));
        push_desc(mk_desc(32'h20, 32'd64));
        push_desc(mk_desc(32'h30, 32'd64));
        go = 1'b1;
        step();
        go = 1'b0;
        rd_done = 1'b1;
        wr_done = 1'b1;
        step();
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        axi_pend = 1'b1;
        axi_err  = mk_err(2'd1, 32'h100);
        rd_err   = mk_err(2'd2, 32'h200);
        step();
        axi_err = '0;
        rd_err  = '0;
        checks++; if (err.addr !== 32'h100 || stats.error !== 1'b1) begin errors++; $display("FAIL err_capture: got addr=%0h error=%0b expected 100 1", err.addr, stats.error); end
        checks++; if (desc_cnt !== 3'd0 || done_cnt !== 16'd1 || rd_valid !== 1'b0) begin errors++; $display("FAIL err_flush: got cnt=%0d done=%0d rv=%0b expected 0 1 0", desc_cnt, done_cnt, rd_valid); end
        wr_err = mk_err(2'd3, 32'h300);
        step();
        wr_err = '0;
        checks++; if (err.addr !== 32'h100 || err.err_type !== 2'd1) begin errors++; $display("FAIL err_sticky: got addr=%0h type=%0d expected 100 1", err.addr, err.err_type); end
        checks++; if (active !== 1'b1 || stats.done !== 1'b0) begin errors++; $display("FAIL err_drain_wait: got active=%0b done=%0b expected 1 0", active, stats.done); end
        axi_pend = 1'b0;
        step();
        checks++; if (stats !== 3'b011) begin errors++; $display("FAIL err_done: got %b expected 011", stats); end
        step();
    endtask

    task automatic test_empty_go();
        axi_pend = 1'b1;
        go       = 1'b1;
        step();
        go = 1'b0;
        checks++; if (active !== 1'b1 || err.valid !== 1'b0 || done_cnt !== 16'd0) begin errors++; $display("FAIL empty_drain: got active=%0b err=%0b cnt=%0d expected 1 0 0", active, err.valid, done_cnt); end
        repeat (4) step();
        checks++; if (active !== 1'b1 || stats.done !== 1'b0) begin errors++; $display("FAIL empty_pend: got active=%0b done=%0b expected 1 0", active, stats.done); end
        axi_pend = 1'b0;
        step();
        checks++; if (stats.done !== 1'b1 || clear_dma !== 1'b1) begin errors++; $display("FAIL empty_done: got done=%0b clear=%0b expected 1 1", stats.done, clear_dma); end
        step();
    endtask

    task automatic test_reset_mid_run();
        push_desc(mk_desc(32'h40, 32'd64));
        push_desc(mk_desc(32'h50, 32'd64));
        go = 1'b1;
        step();
        go = 1'b0;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        checks++; if (active !== 1'b1 || rd_valid !== 1'b0 || wr_valid !== 1'b1) begin errors++; $display("FAIL midrun_flags: got a=%0b rv=%0b wv=%0b expected 1 0 1", active, rd_valid, wr_valid); end
        rstn = 1'b0;
        step();
        checks++; if (desc_cnt !== 3'd0 || desc_ready !== 1'b1 || stats !== 3'b000 || cur_desc !== '0) begin errors++; $display("FAIL midrun_reset_q: got cnt=%0d rdy=%0b stats=%b expected 0 1 000", desc_cnt, desc_ready, stats); end
        checks++; if ({clear_dma, active, rd_valid, wr_valid} !== 4'b0000 || done_cnt !== 16'd0) begin errors++; $display("FAIL midrun_reset_ctrl: got %b cnt=%0d expected 0000 0", {clear_dma, active, rd_valid, wr_valid}, done_cnt); end
        rstn = 1'b1;
        step();
    endtask

`ifdef DMA_CHAIN_ABORT_EN
    task automatic test_abort();
        push_desc(mk_desc(32'h60, 32'd64));
        go = 1'b1;
        step();
        go      = 1'b0;
        abort   = 1'b1;
        rd_done = 1'b1;
        wr_done = 1'b1;
        step();
        abort   = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        checks++; if (done_cnt !== 16'd0 || desc_cnt !== 3'd0 || rd_valid !== 1'b0 || err.valid !== 1'b0) begin errors++; $display("FAIL abort_flush: got done=%0d cnt=%0d rv=%0b err=%0b expected 0 0 0 0", done_cnt, desc_cnt, rd_valid, err.valid); end
        step();
        checks++; if (stats.done !== 1'b1) begin errors++; $display("FAIL abort_done: got %0b expected 1", stats.done); end
        step();
    endtask
`endif

    initial begin
        rstn       = 1'b0;
        desc_valid = 1'b0;
        desc       = '0;
        go         = 1'b0;
        axi_pend   = 1'b0;
        axi_err    = '0;
        rd_done    = 1'b0;
        rd_err     = '0;
        wr_done    = 1'b0;
        wr_err     = '0;
`ifdef DMA_CHAIN_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_chain();
        test_zero_len();
        test_full_no_bypass();
        test_stop_on_err();
        test_empty_go();
        test_reset_mid_run();
`ifdef DMA_CHAIN_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
